// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding and terminator bytes for uart_tx_arbiter.
package uart_arb_pkg;
   typedef enum logic [2:0] {IDLE, GRANT, WAIT_RDY, SEND, WAIT_BUSY} arb_state_t;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after the last winner.
module rr_arbiter #(
   parameter int NREQ = 3
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] last,
   output logic [$clog2(NREQ)-1:0] winner,
   output logic                    any_req
);
   localparam int IDW = $clog2(NREQ);
   logic [IDW-1:0] idx;
   assign any_req = |req;
   // Scan from farthest to nearest so the closest request after last wins.
   always_comb begin
      winner = last;
      idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = IDW'((int'(last) + k) % NREQ);
         if (req[idx]) winner = idx;
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx between NREQ multi-byte message sources.
// Define UART_ARB_CRLF_EN to append CR LF after every message.
module uart_tx_arbiter #(
   parameter int NREQ      = 3,
   parameter int MSG_BYTES = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NREQ-1:0]             req,
   input  logic [NREQ*MSG_BYTES*8-1:0] payload,
   output logic [NREQ-1:0]             gnt,
   input  logic                        tready,
   output logic                        tstart,
   output logic [7:0]                  tbus,
   output logic                        busy,
   output logic [$clog2(NREQ)-1:0]     cur_id
);
   import uart_arb_pkg::*;
   localparam int IDW = $clog2(NREQ);
   localparam int MW  = MSG_BYTES * 8;
   localparam int CW  = $clog2(MSG_BYTES + 3);
`ifdef UART_ARB_CRLF_EN
   localparam logic [CW-1:0] TOTAL = CW'(MSG_BYTES + 2);
`else
   localparam logic [CW-1:0] TOTAL = CW'(MSG_BYTES);
`endif
   arb_state_t     state;
   logic [IDW-1:0] ptr, win, win_q;
   logic           any_req;
   logic [MW-1:0]  shreg;
   logic [CW-1:0]  cnt;
   logic [7:0]     cur_byte;

   rr_arbiter #(.NREQ(NREQ)) u_rr (.req(req), .last(ptr), .winner(win), .any_req(any_req));

`ifdef UART_ARB_CRLF_EN
   assign cur_byte = (cnt < CW'(MSG_BYTES)) ? shreg[MW-1 -: 8] :
                     (cnt == CW'(MSG_BYTES)) ? ASCII_CR : ASCII_LF;
`else
   assign cur_byte = shreg[MW-1 -: 8];
`endif

   assign busy   = state != IDLE;
   assign tstart = state == SEND;
   assign tbus   = tstart ? cur_byte : 8'h00;
   assign gnt    = (state == GRANT) ? NREQ'(1) << win_q : '0;

   // An already-idle transmitter lets GRANT go straight to SEND (tstart two cycles after req).
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         ptr    <= IDW'(NREQ - 1);
         win_q  <= '0;
         cur_id <= '0;
         shreg  <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: if (any_req) begin
               win_q <= win;
               state <= GRANT;
            end
            GRANT: begin
               shreg  <= payload[win_q*MW +: MW];
               ptr    <= win_q;
               cur_id <= win_q;
               cnt    <= '0;
               state  <= tready ? SEND : WAIT_RDY;
            end
            WAIT_RDY: if (tready) state <= SEND;
            SEND: begin
               shreg <= shreg << 8;
               state <= WAIT_BUSY;
            end
            WAIT_BUSY: if (!tready) begin
               cnt   <= cnt + 1'b1;
               state <= (cnt + 1'b1 == TOTAL) ? IDLE : WAIT_RDY;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized bench with a uart_tx ready model and a round-robin message scoreboard.
module tb_uart_tx_arbiter;
   localparam int NREQ = 3, MSG_BYTES = 4, MW = MSG_BYTES * 8;
`ifdef UART_ARB_CRLF_EN
   localparam int TOT = MSG_BYTES + 2;
`else
   localparam int TOT = MSG_BYTES;
`endif
   logic clk = 0, reset = 1, tready = 1, tstart, busy;
   logic [NREQ-1:0] req = '0, gnt;
   logic [NREQ*MW-1:0] payload = '0;
   logic [7:0] tbus;
   logic [1:0] cur_id;

   uart_tx_arbiter #(.NREQ(NREQ), .MSG_BYTES(MSG_BYTES)) dut (
      .clk(clk), .reset(reset), .req(req), .payload(payload), .gnt(gnt),
      .tready(tready), .tstart(tstart), .tbus(tbus), .busy(busy), .cur_id(cur_id));

   always #5 clk = ~clk;

   int errors = 0, checks = 0;
   int n_tstart = 0, low_left = 0, low_max = 10, ptr_m = NREQ - 1, cur_w = 0;
   bit rdy = 1, acc = 0, force_low = 0;
   logic [NREQ-1:0] req_hist = '0, hold_mask = '0;
   logic [7:0] exp_q[$];
   int gnt_log[$];

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int rr_pick(logic [NREQ-1:0] r, int p);
      for (int k = 1; k <= NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   // One clock: uart_tx ready model, byte scoreboard and grant reference.
   task automatic step();
      int w;
      logic [NREQ-1:0] eg;
      req_hist = req;
      @(posedge clk); #1;
      if (acc) begin
         rdy = 0; low_left = low_max; acc = 0;
      end else if (low_left > 0) begin
         low_left--; rdy = (low_left == 0);
      end
      tready = rdy && !force_low;
      if (tstart) begin
         check("tready_at_tstart", tready, 1);
         check("tstart_cur_id", cur_id, cur_w);
         if (exp_q.size() == 0) check("tstart_queue_empty", tstart, 0);
         else check("tbus", tbus, exp_q.pop_front());
         acc = 1; n_tstart++;
      end
      if (exp_q.size() > 0 && !reset) check("busy_during_msg", busy, 1);
      if (gnt != 0) begin
         w = rr_pick(req_hist, ptr_m);
         eg = (w < 0) ? '0 : NREQ'(1) << w;
         check("gnt", gnt, eg);
         check("prev_msg_done", exp_q.size(), 0);
         for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_log.push_back(i);
         if (w >= 0) begin
            for (int b = MSG_BYTES - 1; b >= 0; b--) exp_q.push_back(payload[w*MW + b*8 +: 8]);
`ifdef UART_ARB_CRLF_EN
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
`endif
            ptr_m = w; cur_w = w;
            if (!hold_mask[w]) req[w] = 0;
         end
      end
   endtask

   task automatic wait_grants(int n, int budget, string tag);
      int k = 0;
      while (gnt_log.size() < n && k < budget) begin step(); k++; end
      check(tag, gnt_log.size() >= n, 1);
   endtask

   task automatic wait_tstarts(int n, int budget, string tag);
      int k = 0;
      while (n_tstart < n && k < budget) begin step(); k++; end
      check(tag, n_tstart >= n, 1);
   endtask

   task automatic wait_idle(int budget, string tag);
      int k = 0;
      while ((busy || exp_q.size() != 0 || req != 0) && k < budget) begin step(); k++; end
      check(tag, busy || exp_q.size() != 0 || req != 0, 0);
   endtask

   task automatic wait_uart_ready();
      int k = 0;
      while (!(rdy && low_left == 0) && k < 100) begin step(); k++; end
   endtask

   initial begin
      int g, t0, c1;
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_tstart", tstart, 0);
      check("rst_gnt", gnt, 0);
      check("rst_tbus", tbus, 0);
      check("rst_cur_id", cur_id, 0);
      reset = 0;
      step();
      // Single source, fixed message, 10-cycle busy per byte.
      low_max = 10;
      payload[0 +: MW] = 32'h41424344;
      req = 3'b001;
      t0 = n_tstart;
      step();
      check("t1_gnt_latency", gnt, 3'b001);
      step();
      check("t1_tstart_latency", tstart, 1);
      check("t1_first_byte", tbus, 8'h41);
      wait_tstarts(t0 + TOT, 400, "t1_bytes");
      step();
      check("t1_busy_last_byte", busy, 1);
      step();
      check("t1_busy_end", busy, 0);
      // Point the rotation at source 2 so a full request set starts at 0.
      payload[2*MW +: MW] = $urandom;
      req = 3'b100;
      g = gnt_log.size();
      wait_grants(g + 1, 100, "t2_pre_grant");
      wait_idle(400, "t2_pre_idle");
      low_max = 3;
      for (int i = 0; i < NREQ; i++) payload[i*MW +: MW] = $urandom;
      hold_mask = '1;
      req = '1;
      g = gnt_log.size();
      wait_grants(g + 6, 2000, "t2_grants");
      req = '0;
      hold_mask = '0;
      if (gnt_log.size() >= g + 6)
         for (int j = 0; j < 6; j++) check("t2_order", gnt_log[g+j], j % 3);
      wait_idle(400, "t2_idle");
      // Held req[2] with req[0] arriving mid-message.
      hold_mask = 3'b100;
      payload[2*MW +: MW] = $urandom;
      req = 3'b100;
      g = gnt_log.size();
      wait_grants(g + 1, 100, "t3_grant2");
      wait_tstarts(n_tstart + 2, 200, "t3_mid");
      payload[0 +: MW] = $urandom;
      req[0] = 1;
      wait_grants(g + 3, 1000, "t3_grants");
      hold_mask = '0;
      req = '0;
      if (gnt_log.size() >= g + 3) begin
         check("t3_order0", gnt_log[g], 2);
         check("t3_order1", gnt_log[g+1], 0);
         check("t3_order2", gnt_log[g+2], 2);
      end
      wait_idle(400, "t3_idle");
      // Transmitter not ready for 500 cycles.
      wait_uart_ready();
      force_low = 1;
      payload[MW +: MW] = $urandom;
      req = 3'b010;
      g = gnt_log.size();
      wait_grants(g + 1, 100, "t4_grant");
      t0 = n_tstart;
      repeat (500) step();
      check("t4_no_tstart", n_tstart - t0, 0);
      force_low = 0;
      step();
      check("t4_not_before_ready", tstart, 0);
      step();
      check("t4_fire", tstart, 1);
      check("t4_tbus", tbus, payload[MW + MW - 8 +: 8]);
      wait_idle(400, "t4_idle");
      // Reset after two bytes of a message from source 1.
      payload[MW +: MW] = $urandom;
      req = 3'b010;
      g = gnt_log.size();
      wait_grants(g + 1, 100, "t5_grant");
      wait_tstarts(n_tstart + 2, 200, "t5_two_bytes");
      reset = 1;
      req = '0;
      step();
      check("t5_busy", busy, 0);
      check("t5_tstart", tstart, 0);
      check("t5_gnt", gnt, 0);
      check("t5_cur_id", cur_id, 0);
      reset = 0;
      exp_q.delete();
      ptr_m = NREQ - 1;
      cur_w = 0;
      t0 = n_tstart;
      repeat (30) step();
      check("t5_no_more_bytes", n_tstart - t0, 0);
      payload[MW +: MW] = $urandom;
      payload[2*MW +: MW] = $urandom;
      req = 3'b110;
      g = gnt_log.size();
      wait_grants(g + 1, 100, "t5_regrant");
      if (gnt_log.size() > g) check("t5_first_after_reset", gnt_log[g], 1);
      wait_idle(600, "t5_idle");
      // One-cycle pulses on req[1] while a message from source 0 is in flight.
      payload[0 +: MW] = $urandom;
      req = 3'b001;
      g = gnt_log.size();
      t0 = n_tstart;
      wait_grants(g + 1, 100, "t6_grant");
      for (int p = 0; p < 3; p++) begin
         repeat (5) step();
         if (busy) begin
            payload[MW +: MW] = $urandom;
            req[1] = 1;
            step();
            req[1] = 0;
         end
      end
      wait_idle(600, "t6_idle");
      c1 = 0;
      for (int j = g; j < gnt_log.size(); j++) if (gnt_log[j] == 1) c1++;
      check("t6_pulse_grants", c1, 0);
      check("t6_bytes", n_tstart - t0, TOT);
      // Random traffic against the reference model.
      for (int n = 0; n < 3000; n++) begin
         low_max = $urandom_range(1, 6);
         for (int i = 0; i < NREQ; i++)
            if (!req[i] && !gnt[i] && $urandom_range(0, 19) == 0) begin
               payload[i*MW +: MW] = $urandom;
               req[i] = 1;
            end
         step();
      end
      wait_idle(2000, "rand_idle");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
